// File: rtl/mu0_pkg.sv
// MU0 controller shared definitions: opcodes, ALU function codes, FSM state
// encodings and datapath mux select values. The helper function classifies
// the opcodes that make a data memory access during EXEC.
package mu0_pkg;

    // Opcodes carried in IR[15:12]; 8-15 execute as NOP.
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    // ALU function select.
    localparam logic [1:0] ALU_Y     = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_INC_X = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    // Mux selects.
    localparam logic XSEL_ACC    = 1'b0;
    localparam logic XSEL_PC     = 1'b1;
    localparam logic YSEL_MEM    = 1'b0;
    localparam logic YSEL_IR     = 1'b1;
    localparam logic ASEL_PC     = 1'b0;
    localparam logic ASEL_IR     = 1'b1;

    // 2'b11 is unused; it decodes to no outputs and recovers to StFetch.
    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StExec  = 2'b01,
        StHalt  = 2'b10
    } state_e;

    // Opcodes that access data memory in EXEC and therefore wait for Mem_Rdy.
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f == OP_LDA) || (f == OP_STA) || (f == OP_ADD) || (f == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// MU0 control decode: purely combinational map from the current FSM state,
// opcode, ACC flags, memory ready and reset to every datapath control.
// Ports:
//   state_i     current FSM state
//   f_i         opcode IR[15:12]
//   n_i, z_i    ACC negative / zero flags
//   mem_rdy_i   memory completes its access this cycle
//   rst_i       reset, forces every output to 0
//   *_o         datapath selects, ALU function, enables, strobes, halted
module mu0_decode
    import mu0_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] f_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       mem_rdy_i,
    input  logic       rst_i,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic       addr_sel_o,
    output logic [1:0] alu_fs_o,
    output logic       pc_en_o,
    output logic       ir_en_o,
    output logic       acc_en_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       halted_o
);

    always_comb begin
        x_sel_o    = XSEL_ACC;
        y_sel_o    = YSEL_MEM;
        addr_sel_o = ASEL_PC;
        alu_fs_o   = ALU_Y;
        pc_en_o    = 1'b0;
        ir_en_o    = 1'b0;
        acc_en_o   = 1'b0;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        halted_o   = 1'b0;

        // Reset overrides everything so strobes drop in the same timestep.
        if (!rst_i) begin
            unique case (state_i)
                StFetch: begin
                    addr_sel_o = ASEL_PC;
                    mem_rd_o   = 1'b1;
                    x_sel_o    = XSEL_PC;
                    alu_fs_o   = ALU_INC_X;
                    ir_en_o    = mem_rdy_i;
                    pc_en_o    = mem_rdy_i;
                end
                StExec: begin
                    case (f_i)
                        OP_LDA: begin
                            addr_sel_o = ASEL_IR;
                            mem_rd_o   = 1'b1;
                            y_sel_o    = YSEL_MEM;
                            alu_fs_o   = ALU_Y;
                            acc_en_o   = mem_rdy_i;
                        end
                        OP_STA: begin
                            addr_sel_o = ASEL_IR;
                            mem_wr_o   = 1'b1;
                            x_sel_o    = XSEL_ACC;
                        end
                        OP_ADD: begin
                            addr_sel_o = ASEL_IR;
                            mem_rd_o   = 1'b1;
                            y_sel_o    = YSEL_MEM;
                            x_sel_o    = XSEL_ACC;
                            alu_fs_o   = ALU_ADD;
                            acc_en_o   = mem_rdy_i;
                        end
                        OP_SUB: begin
                            addr_sel_o = ASEL_IR;
                            mem_rd_o   = 1'b1;
                            y_sel_o    = YSEL_MEM;
                            x_sel_o    = XSEL_ACC;
                            alu_fs_o   = ALU_SUB;
                            acc_en_o   = mem_rdy_i;
                        end
                        OP_JMP: begin
                            y_sel_o  = YSEL_IR;
                            alu_fs_o = ALU_Y;
                            pc_en_o  = 1'b1;
                        end
                        OP_JGE: begin
                            y_sel_o  = YSEL_IR;
                            alu_fs_o = ALU_Y;
                            pc_en_o  = ~n_i;
                        end
                        OP_JNE: begin
                            y_sel_o  = YSEL_IR;
                            alu_fs_o = ALU_Y;
                            pc_en_o  = ~z_i;
                        end
                        default: ; // STP and NOPs drive nothing
                    endcase
                end
                StHalt: begin
                    halted_o = 1'b1;
                end
                default: ; // illegal encoding: no outputs this cycle
            endcase
        end
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencing controller: holds the FETCH/EXEC/HALT state register and the
// next-state logic; all control outputs come from mu0_decode.
// Ports:
//   Clk, Reset            clock (rising edge), asynchronous active-high reset
//   F, N, Z, Mem_Rdy      opcode, ACC flags, memory handshake
//   X_sel, Y_sel, Addr_sel, ALU_FS   datapath selects and ALU function
//   PC_En, IR_En, Acc_En  register load enables
//   MEM_rd, MEM_wr        memory strobes
//   Halted                processor stopped after STP
module mu0_control
    import mu0_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Rdy,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic [1:0] ALU_FS,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       MEM_rd,
    output logic       MEM_wr,
    output logic       Halted
);

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: state_d = Mem_Rdy ? StExec : StFetch;
            StExec: begin
                if (F == OP_STP) begin
                    state_d = StHalt;
                end else if (is_mem_op(F)) begin
                    state_d = Mem_Rdy ? StFetch : StExec;
                end else begin
                    state_d = StFetch; // jumps and NOPs are single-cycle
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    mu0_decode u_decode (
        .state_i    (state_q),
        .f_i        (F),
        .n_i        (N),
        .z_i        (Z),
        .mem_rdy_i  (Mem_Rdy),
        .rst_i      (Reset),
        .x_sel_o    (X_sel),
        .y_sel_o    (Y_sel),
        .addr_sel_o (Addr_sel),
        .alu_fs_o   (ALU_FS),
        .pc_en_o    (PC_En),
        .ir_en_o    (IR_En),
        .acc_en_o   (Acc_En),
        .mem_rd_o   (MEM_rd),
        .mem_wr_o   (MEM_wr),
        .halted_o   (Halted)
    );

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: each stimulus cycle pushes its
// hand-computed expected control vector; a negedge monitor pops and compares.
module tb_mu0_control;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] F = 4'd0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       Mem_Rdy = 1'b1;
    logic       X_sel, Y_sel, Addr_sel;
    logic [1:0] ALU_FS;
    logic       PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    string       name_q[$];

    mu0_control dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .F        (F),
        .N        (N),
        .Z        (Z),
        .Mem_Rdy  (Mem_Rdy),
        .X_sel    (X_sel),
        .Y_sel    (Y_sel),
        .Addr_sel (Addr_sel),
        .ALU_FS   (ALU_FS),
        .PC_En    (PC_En),
        .IR_En    (IR_En),
        .Acc_En   (Acc_En),
        .MEM_rd   (MEM_rd),
        .MEM_wr   (MEM_wr),
        .Halted   (Halted)
    );

    always #5 Clk = ~Clk;

    // Vector layout: {halted, wr, rd, acc, ir, pc, fs[1:0], addr, y, x}
    function automatic logic [10:0] ev(input logic x, input logic y, input logic a,
                                       input logic [1:0] fs, input logic pc,
                                       input logic ir, input logic acc, input logic rd,
                                       input logic wr, input logic h);
        return {h, wr, rd, acc, ir, pc, fs, a, y, x};
    endfunction

    function automatic logic [10:0] fetch_exp(input logic rdy);
        return ev(1'b1, 1'b0, 1'b0, 2'b10, rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue the expectation.
    task automatic cyc(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic rdy, input logic [10:0] e, input string nm);
        @(posedge Clk);
        #1;
        Reset   = rst;
        F       = f;
        N       = n;
        Z       = z;
        Mem_Rdy = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare on the falling edge, away from state updates.
    initial begin
        logic [10:0] got, e;
        string nm;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {Halted, MEM_wr, MEM_rd, Acc_En, IR_En, PC_En, ALU_FS,
                       Addr_sel, Y_sel, X_sel};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b (h,wr,rd,acc,ir,pc,fs,a,y,x)",
                             nm, got, e);
                end
            end
        end
    end

    localparam logic [10:0] ZERO = 11'd0;

    initial begin
        logic [10:0] halt_v;
        halt_v = ev(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 1: reset, release, fetch then LDA exec
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, ZERO, "reset_outputs");
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s1_fetch");
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "s1_exec_lda");

        // 2: fetch stalls three cycles
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, fetch_exp(1'b0), "s2_fetch_stall");
        cyc(1'b0, 4'd5, 1'b1, 1'b0, 1'b1, fetch_exp(1'b1), "s2_fetch_done");

        // 3: conditional jumps
        cyc(1'b0, 4'd5, 1'b1, 1'b0, 1'b1,
            ev(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "s3_jge_neg");
        cyc(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s3_fetch_a");
        cyc(1'b0, 4'd5, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "s3_jge_pos");
        cyc(1'b0, 4'd6, 1'b0, 1'b1, 1'b1, fetch_exp(1'b1), "s3_fetch_b");
        cyc(1'b0, 4'd6, 1'b0, 1'b1, 1'b1,
            ev(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "s3_jne_zero");
        cyc(1'b0, 4'd6, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s3_fetch_c");
        cyc(1'b0, 4'd6, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "s3_jne_nz");

        // 6: NOP, ADD, SUB with a stall, JMP ignoring Mem_Rdy
        cyc(1'b0, 4'hA, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s6_fetch_nop");
        cyc(1'b0, 4'hA, 1'b0, 1'b0, 1'b1, ZERO, "s6_nop");
        cyc(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s6_fetch_add");
        cyc(1'b0, 4'd2, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "s6_add");
        cyc(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s6_fetch_sub");
        cyc(1'b0, 4'd3, 1'b0, 1'b0, 1'b0,
            ev(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "s6_sub_wait");
        cyc(1'b0, 4'd3, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "s6_sub_done");
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s6_fetch_jmp");
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b0,
            ev(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "s6_jmp");

        // 5: STA stalled, reset asserted mid-access, then refetch
        cyc(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s5_fetch_sta");
        cyc(1'b0, 4'd1, 1'b0, 1'b0, 1'b0,
            ev(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "s5_sta_wait");
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, ZERO, "s5_reset_mid");
        cyc(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s5_refetch");
        cyc(1'b0, 4'd1, 1'b0, 1'b0, 1'b1,
            ev(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "s5_sta_done");

        // 4: STP then halt under toggling inputs
        cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "s4_fetch_stp");
        cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, ZERO, "s4_stp");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 4'(i), i[0], i[1], i[2], halt_v, "s4_halted");

        // Reset recovers from halt
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, ZERO, "halt_reset");
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, fetch_exp(1'b1), "halt_refetch");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
